// File: rtl/jk_arbiter_ctrl.sv
// Round-robin arbiter that turns two requesters' hold/clear/set/toggle commands
// into J/K/En drives for a 4-bit JK bank, then checks the bank's readback.
module jk_arbiter_ctrl #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] cmd0,
  input  logic [1:0] cmd1,
  input  logic [1:0] sel0,
  input  logic [1:0] sel1,
  input  logic [3:0] Q,
  input  logic       err_clr,
  output logic [3:0] En,
  output logic [3:0] J,
  output logic [3:0] K,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       err,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic       win_reg, win_next;    // 0 = requester 0, 1 = requester 1
  logic       last_reg, last_next;  // requester granted most recently
  logic [1:0] cmd_reg, cmd_next;
  logic [1:0] sel_reg, sel_next;
  logic       exp_reg, exp_next;
  logic       err_reg, err_next;
  logic [3:0] err_cnt_reg, err_cnt_next;
  logic       mismatch;
  logic       apply_phase;

  // Value a JK flip-flop holds after one enabled edge with the given command.
  function automatic logic jk_result(input logic [1:0] c, input logic q);
    logic r;
    case (c)
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      win_reg     <= 1'b0;
      last_reg    <= 1'b1;
      cmd_reg     <= 2'b00;
      sel_reg     <= 2'b00;
      exp_reg     <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      win_reg     <= win_next;
      last_reg    <= last_next;
      cmd_reg     <= cmd_next;
      sel_reg     <= sel_next;
      exp_reg     <= exp_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    last_next  = last_reg;
    cmd_next   = cmd_reg;
    sel_next   = sel_reg;
    exp_next   = exp_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          // Contention goes to whichever requester was not served last.
          win_next   = (req0 && req1) ? ~last_reg : req1;
          last_next  = win_next;
          cmd_next   = win_next ? cmd1 : cmd0;
          sel_next   = win_next ? sel1 : sel0;
          exp_next   = jk_result(cmd_next, Q[sel_next]);
          state_next = APPLY;
        end
      end
      APPLY:   state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mismatch = CHECK_EN && (state_reg == CHECK) && (Q[sel_reg] != exp_reg);

  // A mismatch coincident with err_clr restarts the count at one.
  always_comb begin
    err_next     = err_reg;
    err_cnt_next = err_cnt_reg;
    if (mismatch) begin
      err_next = 1'b1;
      if (err_clr)
        err_cnt_next = 4'd1;
      else if (err_cnt_reg != 4'd15)
        err_cnt_next = err_cnt_reg + 4'd1;
    end else if (err_clr) begin
      err_next     = 1'b0;
      err_cnt_next = 4'd0;
    end
  end

  assign apply_phase = (state_reg == APPLY);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_drive
      assign En[gi] = apply_phase && (sel_reg == 2'(gi));
      assign J[gi]  = En[gi] & cmd_reg[1];
      assign K[gi]  = En[gi] & cmd_reg[0];
    end
  endgenerate

  assign gnt0    = apply_phase && !win_reg;
  assign gnt1    = apply_phase && win_reg;
  assign busy    = (state_reg != IDLE);
  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;

endmodule
